// File: rtl/fb_arbiter_pkg.sv
// rtl/fb_arbiter_pkg.sv - shared geometry, FSM encoding and helpers for the framebuffer arbiter
package fb_arbiter_pkg;

  localparam int COLS     = 240;
  localparam int PAGES    = 8;
  localparam int MAX_WAIT = 4;
  localparam int X_W      = 8;
  localparam int Y_W      = 3;
  localparam int ADDR_W   = X_W + Y_W;
  localparam int DEPTH    = 1 << ADDR_W;
  localparam int WAIT_W   = 3;

  localparam logic [X_W-1:0]    COLS_X   = X_W'(COLS);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_RMW_WR = 1'b1
  } state_e;

  typedef logic [ADDR_W-1:0] addr_t;

  function automatic addr_t fb_addr(input logic [Y_W-1:0] y, input logic [X_W-1:0] x);
    return {y, x};
  endfunction

  function automatic logic [7:0] rmw_merge(input logic [7:0] old_byte, input logic [7:0] data,
                                           input logic [7:0] mask);
    return (old_byte & ~mask) | (data & mask);
  endfunction

endpackage

// File: rtl/fb_arbiter_if.sv
// rtl/fb_arbiter_if.sv - LCD refresh read port and host masked-write port
interface fb_arbiter_if;
  import fb_arbiter_pkg::*;

  logic           lcd_req;
  logic [X_W-1:0] lcd_x;
  logic [Y_W-1:0] lcd_y;
  logic           lcd_ack;
  logic [7:0]     lcd_data;
  logic           lcd_valid;

  logic           host_valid;
  logic           host_ready;
  logic [X_W-1:0] host_x;
  logic [Y_W-1:0] host_y;
  logic [7:0]     host_data;
  logic [7:0]     host_mask;

  modport master (
    output lcd_req, lcd_x, lcd_y, host_valid, host_x, host_y, host_data, host_mask,
    input  lcd_ack, lcd_data, lcd_valid, host_ready
  );

  modport slave (
    input  lcd_req, lcd_x, lcd_y, host_valid, host_x, host_y, host_data, host_mask,
    output lcd_ack, lcd_data, lcd_valid, host_ready
  );

endinterface

// File: rtl/fb_arbiter_ram.sv
// rtl/fb_arbiter_ram.sv - single-port byte-wide framebuffer RAM, registered read
module fb_arbiter_ram #(
  parameter int DEPTH  = 2048,
  parameter int ADDR_W = 11
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        wdata_i,
  output logic [7:0]        rdata_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  // Read data holds across writes so an RMW can merge against it.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fb_arbiter.sv
// rtl/fb_arbiter.sv - shares the framebuffer between LCD refresh reads and host masked writes
// LCD reads win unless the host has already lost MAX_WAIT cycles; partial masks take two cycles.
module fb_arbiter
  import fb_arbiter_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  fb_arbiter_if.slave      bus,
  input  logic [PAGES-1:0] dirty_clr_i,
  output logic [PAGES-1:0] dirty_page_o
);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [PAGES-1:0]    dirty_q, dirty_d;
  logic                lcd_valid_q, lcd_valid_d;
  logic                lcd_oob_q, lcd_oob_d;

  logic                host_oob, mask_full, mask_none, host_single;
  logic                wait_full, host_win;
  logic                lcd_ack, host_ready, host_commit;
  logic                ram_en, ram_we;
  addr_t               ram_addr;
  logic [7:0]          ram_wdata, ram_rdata;
  logic [PAGES-1:0]    page_hot;

  assign host_oob    = bus.host_x >= COLS_X;
  assign mask_full   = bus.host_mask == 8'hFF;
  assign mask_none   = bus.host_mask == 8'h00;
  assign host_single = mask_full | mask_none | host_oob;
  assign wait_full   = wait_q == WAIT_MAX;
  assign host_win    = bus.host_valid & (!bus.lcd_req | wait_full);
  assign page_hot    = {{(PAGES-1){1'b0}}, 1'b1} << bus.host_y;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      wait_q      <= '0;
      dirty_q     <= '1;
      lcd_valid_q <= 1'b0;
      lcd_oob_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      dirty_q     <= dirty_d;
      lcd_valid_q <= lcd_valid_d;
      lcd_oob_q   <= lcd_oob_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (host_win && !host_single) state_d = ST_RMW_WR;
      ST_RMW_WR: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    lcd_ack     = 1'b0;
    host_ready  = 1'b0;
    host_commit = 1'b0;
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = fb_addr(bus.host_y, bus.host_x);
    ram_wdata   = bus.host_data;
    lcd_oob_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        lcd_ack = bus.lcd_req & !host_win;
        if (lcd_ack) begin
          lcd_oob_d = bus.lcd_x >= COLS_X;
          ram_en    = !lcd_oob_d;
          ram_addr  = fb_addr(bus.lcd_y, bus.lcd_x);
        end else if (host_win) begin
          if (host_single) begin
            host_ready  = 1'b1;
            host_commit = mask_full & !host_oob;
            ram_en      = host_commit;
            ram_we      = host_commit;
          end else begin
            ram_en = 1'b1;
          end
        end
      end
      ST_RMW_WR: begin
        host_ready  = 1'b1;
        host_commit = 1'b1;
        ram_en      = 1'b1;
        ram_we      = 1'b1;
        ram_wdata   = rmw_merge(ram_rdata, bus.host_data, bus.host_mask);
      end
      default: ;
    endcase
  end

  // The RMW write cycle counts as the host being served, so the counter stays at zero.
  always_comb begin
    wait_d = wait_q;
    if (state_q == ST_RMW_WR || host_win) begin
      wait_d = '0;
    end else if (bus.host_valid && !wait_full) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_comb begin
    lcd_valid_d = lcd_ack;
    dirty_d     = (dirty_q & ~dirty_clr_i) | (host_commit ? page_hot : '0);
  end

  fb_arbiter_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (clk_i),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  assign bus.lcd_ack    = lcd_ack;
  assign bus.host_ready = host_ready;
  assign bus.lcd_valid  = lcd_valid_q;
  assign bus.lcd_data   = (lcd_valid_q && !lcd_oob_q) ? ram_rdata : 8'h00;
  assign dirty_page_o   = dirty_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// tb/tb_fb_arbiter.sv - directed and random checks of fb_arbiter against a framebuffer model
module tb_fb_arbiter;
  import fb_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] dirty_clr;
  logic [7:0] dirty_page;

  fb_arbiter_if bus();

  fb_arbiter dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .bus          (bus),
    .dirty_clr_i  (dirty_clr),
    .dirty_page_o (dirty_page)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // framebuffer model: byte contents plus whether the byte has a known value
  bit [7:0] m_mem   [2048];
  bit       m_known [2048];
  bit [7:0] m_dirty;
  int       m_wait;
  bit       m_rmw;
  bit       m_valid;
  bit [7:0] m_data;
  bit       m_data_known;

  logic g_ack, g_ready;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit lr, input bit [7:0] lx, input bit [2:0] ly, input bit hv,
                       input bit [7:0] hx, input bit [2:0] hy, input bit [7:0] hd,
                       input bit [7:0] hm, input bit [7:0] clr);
    bus.lcd_req = lr; bus.lcd_x = lx; bus.lcd_y = ly;
    bus.host_valid = hv; bus.host_x = hx; bus.host_y = hy;
    bus.host_data = hd; bus.host_mask = hm; dirty_clr = clr;
  endtask

  task automatic step(input bit lr, input bit [7:0] lx, input bit [2:0] ly, input bit hv,
                      input bit [7:0] hx, input bit [2:0] hy, input bit [7:0] hd,
                      input bit [7:0] hm, input bit [7:0] clr, output bit ready);
    int       a;
    bit       win, ack, nvalid, nknown;
    bit [7:0] ndata, set;
    @(negedge clk);
    drive(lr, lx, ly, hv, hx, hy, hd, hm, clr);
    #1;
    chk("lcd_valid", bus.lcd_valid, m_valid);
    if (!m_valid) chk("lcd_data_idle", bus.lcd_data, 8'h00);
    else if (m_data_known) chk("lcd_data", bus.lcd_data, m_data);
    chk("dirty_page", dirty_page, m_dirty);
    set = 8'h00; nvalid = 0; ndata = 8'h00; nknown = 0; ready = 0; ack = 0;
    a = int'(hy) * 256 + int'(hx);
    if (m_rmw) begin
      ready = 1;
      if (m_known[a]) m_mem[a] = (m_mem[a] & ~hm) | (hd & hm);
      set[hy] = 1'b1;
      m_rmw = 0;
      m_wait = 0;
    end else begin
      win = hv && (!lr || m_wait == MAX_WAIT);
      ack = lr && !win;
      if (ack) begin
        nvalid = 1;
        if (int'(lx) >= COLS) begin
          nknown = 1;
        end else begin
          ndata  = m_mem[int'(ly) * 256 + int'(lx)];
          nknown = m_known[int'(ly) * 256 + int'(lx)];
        end
      end
      if (win) begin
        m_wait = 0;
        if (int'(hx) >= COLS || hm == 8'h00) begin
          ready = 1;
        end else if (hm == 8'hFF) begin
          ready = 1;
          m_mem[a] = hd;
          m_known[a] = 1;
          set[hy] = 1'b1;
        end else begin
          m_rmw = 1;
        end
      end else if (hv && m_wait < MAX_WAIT) begin
        m_wait++;
      end
    end
    g_ack = bus.lcd_ack;
    g_ready = bus.host_ready;
    chk("lcd_ack", bus.lcd_ack, ack);
    chk("host_ready", bus.host_ready, ready);
    m_valid = nvalid; m_data = ndata; m_data_known = nknown;
    m_dirty = (m_dirty & ~clr) | set;
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    m_rmw = 0; m_wait = 0; m_dirty = 8'hFF; m_valid = 0;
    chk("rst_lcd_valid", bus.lcd_valid, 1'b0);
    chk("rst_lcd_data", bus.lcd_data, 8'h00);
    chk("rst_lcd_ack", bus.lcd_ack, 1'b0);
    chk("rst_host_ready", bus.host_ready, 1'b0);
    chk("rst_dirty", dirty_page, 8'hFF);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit       rdy;
    int       acks;
    bit       hv;
    bit [7:0] hx, hd, hm, old_b;
    bit [2:0] hy;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();

    // read at (5,0): ack in the request cycle, valid on the next
    step(1, 5, 0, 0, 0, 0, 0, 0, 0, rdy);
    chk("t1_ack", g_ack, 1'b1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, rdy);

    for (int y = 0; y < PAGES; y++)
      for (int x = 0; x < COLS; x++)
        step(0, 0, 0, 1, 8'(x), 3'(y), 8'($urandom), 8'hFF, 0, rdy);

    step(0, 0, 0, 1, 10, 2, 8'hA5, 8'hFF, 0, rdy);
    chk("t2_ready", g_ready, 1'b1);
    step(1, 10, 2, 0, 0, 0, 0, 0, 0, rdy);
    #1 chk("t2_read", bus.lcd_data, 8'hA5);

    step(0, 0, 0, 1, 10, 2, 8'h0F, 8'h0F, 0, rdy);
    chk("t3_first_ready", g_ready, 1'b0);
    step(0, 0, 0, 1, 10, 2, 8'h0F, 8'h0F, 0, rdy);
    chk("t3_second_ready", g_ready, 1'b1);
    step(1, 10, 2, 0, 0, 0, 0, 0, 0, rdy);
    #1 chk("t3_read", bus.lcd_data, 8'hAF);

    acks = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, 8'(i), 1, 1, 20, 3, 8'h3C, 8'hFF, 0, rdy);
      if (g_ready) break;
      acks += int'(g_ack);
    end
    chk("t4_acks", acks, 4);
    chk("t4_granted", g_ready, 1'b1);
    chk("t4_ack_in_grant", g_ack, 1'b0);

    step(0, 0, 0, 0, 0, 0, 0, 0, 8'hFF, rdy);
    step(0, 0, 0, 1, 30, 2, 8'h11, 8'hFF, 8'h04, rdy);
    #1 chk("t5_set_wins", dirty_page, 8'h04);
    step(0, 0, 0, 0, 0, 0, 0, 0, 8'h04, rdy);
    #1 chk("t5_clear", dirty_page, 8'h00);

    step(0, 0, 0, 1, 240, 4, 8'h77, 8'hFF, 0, rdy);
    chk("t6_oob_ready", g_ready, 1'b1);
    #1 chk("t6_oob_dirty", dirty_page, 8'h00);
    step(1, 240, 4, 0, 0, 0, 0, 0, 0, rdy);
    #1 chk("t6_oob_read", bus.lcd_data, 8'h00);

    old_b = m_mem[5 * 256 + 50];
    step(0, 0, 0, 1, 50, 5, ~old_b, 8'h0F, 0, rdy);
    chk("t6_rmw_start", g_ready, 1'b0);
    do_reset();
    step(1, 50, 5, 0, 0, 0, 0, 0, 0, rdy);
    #1 chk("t6_rmw_aborted", bus.lcd_data, 32'(old_b));

    hv = 0; hx = 0; hy = 0; hd = 0; hm = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!hv && $urandom_range(2) == 0) begin
        hv = 1;
        hx = 8'($urandom_range(0, 250));
        hy = 3'($urandom);
        hd = 8'($urandom);
        case ($urandom_range(3))
          0: hm = 8'hFF;
          1: hm = 8'h00;
          default: hm = 8'($urandom);
        endcase
      end
      step($urandom_range(9) < 7, 8'($urandom_range(0, 245)), 3'($urandom), hv, hx, hy, hd, hm,
           ($urandom_range(15) == 0) ? 8'($urandom) : 8'h00, rdy);
      if (rdy) hv = 0;
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, rdy);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
